// File: rtl/fetch_ctrl.sv
// Fetch-stage control: selects the next PC (redirect, deferred redirect or sequential)
// and holds the F->D pipeline register with stall/flush handling.
module fetch_ctrl #(
  parameter logic [31:0] INIT_PC = 32'h0000_3000,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] NextPC,
  output logic        PC_WE,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic        pend_valid,
  output logic        misalign
);

  logic [31:0] pend_target_r;
  logic        pend_valid_r;
  logic [31:0] d_pc_r;
  logic [31:0] d_instr_r;
  logic        d_valid_r;

  // Next-PC selection; a redirect during a stall is parked in the pending register instead.
  always_comb begin
    NextPC = F_PC + 32'd4;
    if (redir_valid && !stall) begin
      NextPC = redir_target;
    end else if (pend_valid_r && !stall) begin
      NextPC = pend_target_r;
    end else begin
      NextPC = F_PC + 32'd4;
    end
  end

  assign PC_WE    = ~stall;
  assign misalign = (F_PC[1:0] != 2'b00);

  // Deferred-redirect register: newest redirect wins, consumed on the first unstalled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_r  <= 1'b0;
      pend_target_r <= INIT_PC;
    end else if (redir_valid && stall) begin
      pend_valid_r  <= 1'b1;
      pend_target_r <= redir_target;
    end else if (!stall) begin
      pend_valid_r  <= 1'b0;
      pend_target_r <= pend_target_r;
    end else begin
      pend_valid_r  <= pend_valid_r;
      pend_target_r <= pend_target_r;
    end
  end

  // F->D pipeline register; flush injects a NOP even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc_r    <= INIT_PC;
      d_instr_r <= NOP;
      d_valid_r <= 1'b0;
    end else if (flush) begin
      d_pc_r    <= F_PC;
      d_instr_r <= NOP;
      d_valid_r <= 1'b0;
    end else if (!stall) begin
      d_pc_r    <= F_PC;
      d_instr_r <= F_Instr;
      d_valid_r <= 1'b1;
    end else begin
      d_pc_r    <= d_pc_r;
      d_instr_r <= d_instr_r;
      d_valid_r <= d_valid_r;
    end
  end

  assign D_PC       = d_pc_r;
  assign D_Instr    = d_instr_r;
  assign D_valid    = d_valid_r;
  assign pend_valid = pend_valid_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        stall;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] NextPC;
  logic        PC_WE;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_valid;
  logic        pend_valid;
  logic        misalign;

  int checks_cnt;
  int errors_cnt;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .F_PC         (F_PC),
    .F_Instr      (F_Instr),
    .stall        (stall),
    .flush        (flush),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .NextPC       (NextPC),
    .PC_WE        (PC_WE),
    .D_PC         (D_PC),
    .D_Instr      (D_Instr),
    .D_valid      (D_valid),
    .pend_valid   (pend_valid),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic st,
                       input logic fl, input logic rv, input logic [31:0] rt);
    F_PC = pc; F_Instr = ins; stall = st; flush = fl; redir_valid = rv; redir_target = rt;
    #1;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset = 1'b1;
    drive(32'h0000_3000, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h0000_5000);
    check_val("rst_nextpc_comb", NextPC, 32'h0000_5000);
    check_val("rst_pcwe_comb", {31'd0, PC_WE}, 32'd1);
    step();
    step();
    reset = 1'b0;
    check_val("rst_d_pc", D_PC, 32'h0000_3000);
    check_val("rst_d_instr", D_Instr, 32'h0000_0000);
    check_val("rst_d_valid", {31'd0, D_valid}, 32'd0);
    check_val("rst_pend", {31'd0, pend_valid}, 32'd0);

    // Sequential fetch
    drive(32'h0000_3000, 32'h2408_000A, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("seq_nextpc", NextPC, 32'h0000_3004);
    check_val("seq_pcwe", {31'd0, PC_WE}, 32'd1);
    check_val("seq_misalign", {31'd0, misalign}, 32'd0);
    step();
    check_val("seq_d_pc", D_PC, 32'h0000_3000);
    check_val("seq_d_instr", D_Instr, 32'h2408_000A);
    check_val("seq_d_valid", {31'd0, D_valid}, 32'd1);

    // Redirect with delay slot kept
    drive(32'h0000_3008, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
    check_val("redir_nextpc", NextPC, 32'h0000_3040);
    step();
    check_val("redir_d_pc", D_PC, 32'h0000_3008);
    check_val("redir_d_instr", D_Instr, 32'h1000_0003);
    check_val("redir_pend", {31'd0, pend_valid}, 32'd0);

    // Deferred redirect: stall for 3 cycles
    drive(32'h0000_300C, 32'hAAAA_0001, 1'b1, 1'b0, 1'b1, 32'h0000_3100);
    check_val("defer_pcwe", {31'd0, PC_WE}, 32'd0);
    check_val("defer_nextpc_stalled", NextPC, 32'h0000_3010);
    step();
    check_val("defer_pend_set", {31'd0, pend_valid}, 32'd1);
    check_val("defer_d_held", D_PC, 32'h0000_3008);
    drive(32'h0000_300C, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check_val("defer_pend_hold", {31'd0, pend_valid}, 32'd1);
    check_val("defer_d_instr_held", D_Instr, 32'h1000_0003);
    drive(32'h0000_300C, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("defer_nextpc", NextPC, 32'h0000_3100);
    step();
    check_val("defer_pend_clr", {31'd0, pend_valid}, 32'd0);
    check_val("defer_d_pc", D_PC, 32'h0000_300C);
    drive(32'h0000_3100, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("defer_after_seq", NextPC, 32'h0000_3104);
    step();

    // Overwrite pending while stalled, then apply
    drive(32'h0000_3104, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_3200);
    step();
    drive(32'h0000_3104, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_3300);
    step();
    drive(32'h0000_3104, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("ovr_nextpc", NextPC, 32'h0000_3300);
    step();
    // New unstalled redirect beats a pending one and clears it
    drive(32'h0000_3300, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_3500);
    step();
    drive(32'h0000_3300, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3400);
    check_val("new_beats_pend", NextPC, 32'h0000_3400);
    step();
    check_val("new_clr_pend", {31'd0, pend_valid}, 32'd0);

    // Flush overrides stall
    drive(32'h0000_3050, 32'h2408_0001, 1'b1, 1'b1, 1'b0, 32'h0);
    check_val("flush_pcwe", {31'd0, PC_WE}, 32'd0);
    step();
    check_val("flush_d_instr", D_Instr, 32'h0000_0000);
    check_val("flush_d_valid", {31'd0, D_valid}, 32'd0);
    check_val("flush_d_pc", D_PC, 32'h0000_3050);

    // Reset mid-operation with a redirect present
    drive(32'h0000_3060, 32'h2408_0002, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h0000_3064, 32'h2408_0003, 1'b1, 1'b0, 1'b1, 32'h0000_3700);
    step();
    check_val("mid_pend_pre", {31'd0, pend_valid}, 32'd1);
    check_val("mid_dvalid_pre", {31'd0, D_valid}, 32'd1);
    reset = 1'b1;
    drive(32'h0000_3064, 32'h2408_0003, 1'b0, 1'b0, 1'b1, 32'h0000_3800);
    step();
    reset = 1'b0;
    check_val("mid_pend", {31'd0, pend_valid}, 32'd0);
    check_val("mid_dvalid", {31'd0, D_valid}, 32'd0);
    check_val("mid_d_pc", D_PC, 32'h0000_3000);
    drive(32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("mid_no_stale_redir", NextPC, 32'h0000_3004);

    // Wrap and misalign
    drive(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("wrap_nextpc", NextPC, 32'h0000_0000);
    drive(32'h0000_3002, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("mis_flag", {31'd0, misalign}, 32'd1);
    check_val("mis_nextpc", NextPC, 32'h0000_3006);
    step();
    check_val("mis_d_pc", D_PC, 32'h0000_3002);
    check_val("mis_d_instr", D_Instr, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
